axis_stim_seq: RTL and testbench
================================

AXIS_STIM_SEQ -- requirements
Module: axis_stim_seq

Interface
REQ-001 Parameter CNT_W, default 16: width of the frame-count configuration and the frame counter.
REQ-002 Parameter GAP_W, default 16: width of the inter-frame gap configuration and the gap counter.
REQ-003 Parameter TO_CYCLES, default 4096: stall watchdog limit in clk cycles (used only when the Configuration macro is defined).
REQ-004 Clock and reset: single clock `clk`; reset `rstn` is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle request to begin a sequence.
REQ-008 abort  in  1  single-cycle request to stop a sequence immediately.
REQ-009 cfg_frame_len  in  8  beats per frame, forwarded to the stimulus generator.
REQ-010 cfg_num_frames  in  CNT_W  frames per sequence; 0 means run continuously until abort.
REQ-011 cfg_gap  in  GAP_W  idle cycles between frames; 0 means back-to-back frames.
REQ-012 mon_tvalid, mon_tready, mon_tlast  in  1 each  tap on the generator's AXI-Stream output.
REQ-013 stim_en  out  1  enable to the generator.
REQ-014 stim_clr  out  1  clear to the generator.
REQ-015 stim_frame_len  out  8  latched frame length.
REQ-016 busy  out  1  high while not IDLE.
REQ-017 done  out  1  one-cycle pulse on normal completion.
REQ-018 aborted  out  1  one-cycle pulse on abort or timeout.
REQ-019 cfg_err  out  1  one-cycle pulse when a start is rejected.
REQ-020 frames_sent  out  CNT_W  count of completed frames.
REQ-021 timeout  out  1  sticky stall flag.

Function
REQ-022 FSM states: IDLE, CLR, RUN, GAP, DONE; all outputs registered.
REQ-023 IDLE, start=1, abort=0, cfg_frame_len!=0: latch all cfg_* inputs, clear frames_sent to 0, enter CLR.
REQ-024 IDLE, start=1, cfg_frame_len=0: pulse cfg_err for one cycle and remain in IDLE.
REQ-025 CLR: stim_clr=1 for exactly one cycle, then enter RUN.
REQ-026 RUN: stim_en=1.
REQ-027 Frame end: a cycle with mon_tvalid & mon_tready & mon_tlast increments frames_sent.
REQ-028 Frame end with the latched count reached (frames_sent+1 == num_frames, num_frames!=0): enter DONE.
REQ-029 Frame end, count not reached, gap>0: enter GAP.
REQ-030 Frame end, count not reached, gap=0: remain in RUN.
REQ-031 stim_en deasserts in the cycle after the terminating tlast handshake.
REQ-032 GAP: stim_en=0 for exactly gap cycles, then return to RUN.
REQ-033 DONE: done=1 for one cycle, then enter IDLE; stim_en=0.
REQ-034 Abort in any non-IDLE state: go to IDLE next cycle, stim_en=0, pulse aborted, no done pulse; frames_sent is held.
REQ-035 abort in IDLE: ignored.
REQ-036 abort and start in the same cycle in IDLE: abort wins; remain in IDLE with no pulses.
REQ-037 start while busy=1: ignored, with no cfg_err.
REQ-038 Continuous mode (num_frames=0): frames_sent wraps from 2^CNT_W-1 to 0; the sequence never completes without abort.
REQ-039 cfg_* changes while busy: no effect until the next accepted start.
REQ-040 tlast handshakes outside RUN: not counted.

Reset
REQ-041 rstn low asynchronously forces IDLE and sets every output to 0 (stim_en, stim_clr, stim_frame_len, busy, done, aborted, cfg_err, frames_sent, timeout), clears all counters, and clears the latched configuration.
REQ-042 Reset mid-sequence drops stim_en immediately; no done or aborted pulse is produced.

Configuration
REQ-043 Macro AXIS_STIM_SEQ_TIMEOUT_EN defined: a watchdog counts RUN cycles with no mon_tvalid & mon_tready beat. Reaching TO_CYCLES sets timeout, pulses aborted and enters IDLE. timeout clears only on reset or on an accepted start; any accepted beat restarts the count.
REQ-044 Macro undefined: timeout is tied to 0 and no watchdog counter is present.

Verification
REQ-045 frame_len=32, num_frames=3, gap=10, tready held 1 -> one stim_clr pulse; 3 frames with exactly 10 stim_en-low cycles between them; frames_sent=3; one done pulse.
REQ-046 num_frames=0, gap=0, abort after 5 frames -> stim_en low next cycle; aborted pulse; frames_sent=5; no done.
REQ-047 start with cfg_frame_len=0 -> cfg_err pulse; busy stays 0.
REQ-048 start and abort in the same IDLE cycle -> no state change.
REQ-049 rstn low mid-RUN -> all outputs 0 immediately.
REQ-050 Macro defined, TO_CYCLES=100, tready held 0 in RUN -> timeout=1 and aborted pulse at cycle 100.

Source files
------------

// File: rtl/axis_stim_seq.sv
// axis_stim_seq: sequences an AXI-Stream stimulus generator through
// clear / run / inter-frame gap phases and counts completed frames by
// tapping the generator's output handshake.
// Optional feature macro: AXIS_STIM_SEQ_TIMEOUT_EN enables a stall watchdog
// that aborts the sequence after TO_CYCLES RUN cycles without a beat.
module axis_stim_seq #(
  parameter int CNT_W     = 16,
  parameter int GAP_W     = 16,
  parameter int TO_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       cfg_frame_len,
  input  logic [CNT_W-1:0] cfg_num_frames,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  output logic             stim_en,
  output logic             stim_clr,
  output logic [7:0]       stim_frame_len,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err,
  output logic [CNT_W-1:0] frames_sent,
  output logic             timeout
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, GAP, DONE} state_t;

  state_t           state_q;
  logic             stim_en_q;
  logic             stim_clr_q;
  logic [7:0]       frame_len_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic             cfg_err_q;
  logic [CNT_W-1:0] frames_sent_q;
  logic [CNT_W-1:0] num_frames_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt_q;

  logic             beat;
  logic             frame_end;
  logic [CNT_W-1:0] frames_inc;
  logic             count_reached;

  assign beat          = mon_tvalid & mon_tready;
  assign frame_end     = beat & mon_tlast;
  assign frames_inc    = frames_sent_q + CNT_W'(1);
  // A zero frame count means continuous mode, which never completes.
  assign count_reached = (num_frames_q != '0) && (frames_inc == num_frames_q);

`ifdef AXIS_STIM_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TO_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_q;
  logic            wd_expire;

  // Stall detected on the RUN cycle that would make the idle count reach the limit.
  assign wd_expire = (state_q == RUN) && !beat && (wd_cnt_q == WD_W'(TO_CYCLES - 1));
  assign timeout   = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      stim_en_q     <= 1'b0;
      stim_clr_q    <= 1'b0;
      frame_len_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      frames_sent_q <= '0;
      num_frames_q  <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
`ifdef AXIS_STIM_SEQ_TIMEOUT_EN
      wd_cnt_q      <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; each lasts a single cycle.
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      stim_clr_q <= 1'b0;

      if ((state_q != IDLE) && abort) begin
        state_q   <= IDLE;
        stim_en_q <= 1'b0;
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            // Abort in the same cycle cancels the start with no side effects.
            if (start && !abort) begin
              if (cfg_frame_len == 8'd0) begin
                cfg_err_q <= 1'b1;
              end else begin
                frame_len_q   <= cfg_frame_len;
                num_frames_q  <= cfg_num_frames;
                gap_q         <= cfg_gap;
                frames_sent_q <= '0;
                stim_clr_q    <= 1'b1;
                busy_q        <= 1'b1;
                state_q       <= CLR;
`ifdef AXIS_STIM_SEQ_TIMEOUT_EN
                wd_cnt_q      <= '0;
                timeout_q     <= 1'b0;
`endif
              end
            end
          end

          CLR: begin
            stim_en_q <= 1'b1;
            state_q   <= RUN;
          end

          RUN: begin
            if (frame_end) begin
              frames_sent_q <= frames_inc;
              if (count_reached) begin
                stim_en_q <= 1'b0;
                done_q    <= 1'b1;
                state_q   <= DONE;
              end else if (gap_q != '0) begin
                stim_en_q <= 1'b0;
                gap_cnt_q <= gap_q;
                state_q   <= GAP;
              end
            end
`ifdef AXIS_STIM_SEQ_TIMEOUT_EN
            // Expiry implies no beat, so it never collides with a frame end.
            if (wd_expire) begin
              timeout_q <= 1'b1;
              aborted_q <= 1'b1;
              stim_en_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end else if (beat) begin
              wd_cnt_q <= '0;
            end else begin
              wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
`endif
          end

          GAP: begin
            // gap_cnt_q was loaded with the gap length, so GAP lasts exactly that many cycles.
            if (gap_cnt_q <= GAP_W'(1)) begin
              stim_en_q <= 1'b1;
              state_q   <= RUN;
            end else begin
              gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
          end

          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end

          default: begin
            stim_en_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        endcase
      end
    end
  end

  assign stim_en        = stim_en_q;
  assign stim_clr       = stim_clr_q;
  assign stim_frame_len = frame_len_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign cfg_err        = cfg_err_q;
  assign frames_sent    = frames_sent_q;

endmodule

// File: tb/tb_axis_stim_seq.sv
// Directed bench for axis_stim_seq: a small beat generator model answers
// stim_en, and each scenario task compares DUT outputs to hand-derived values.
module tb_axis_stim_seq;

  localparam int CNT_W = 3;
  localparam int GAP_W = 16;
  localparam int TO_CYC = 100;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic             abort;
  logic [7:0]       cfg_frame_len;
  logic [CNT_W-1:0] cfg_num_frames;
  logic [GAP_W-1:0] cfg_gap;
  logic             mon_tvalid;
  logic             mon_tready;
  logic             mon_tlast;
  logic             stim_en;
  logic             stim_clr;
  logic [7:0]       stim_frame_len;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             cfg_err;
  logic [CNT_W-1:0] frames_sent;
  logic             timeout;

  int vectors = 0;
  int miscompares = 0;

  // Generator model state.
  int   beat_cnt = 0;
  int   gen_len = 1;
  logic tready_val = 1'b1;
  logic fe_seen = 1'b0;

  axis_stim_seq #(
    .CNT_W(CNT_W),
    .GAP_W(GAP_W),
    .TO_CYCLES(TO_CYC)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .abort(abort),
    .cfg_frame_len(cfg_frame_len),
    .cfg_num_frames(cfg_num_frames),
    .cfg_gap(cfg_gap),
    .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready),
    .mon_tlast(mon_tlast),
    .stim_en(stim_en),
    .stim_clr(stim_clr),
    .stim_frame_len(stim_frame_len),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .cfg_err(cfg_err),
    .frames_sent(frames_sent),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // One clock: records whether this edge carried a frame-end handshake,
  // clears single-cycle requests, then updates the generator model.
  task automatic step();
    logic hs;
    hs = mon_tvalid & mon_tready;
    fe_seen = hs & mon_tlast;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    if (stim_clr) beat_cnt = 0;
    else if (hs) beat_cnt = fe_seen ? 0 : beat_cnt + 1;
    mon_tvalid = stim_en;
    mon_tready = tready_val;
    mon_tlast  = stim_en && (beat_cnt == gen_len - 1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({stim_en, stim_clr, busy, done, aborted, cfg_err, timeout} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {stim_en, stim_clr, busy, done, aborted, cfg_err, timeout});
    end
    vectors++;
    if ({stim_frame_len, frames_sent} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: len %0d frames %0d expected 0 0", stim_frame_len, frames_sent);
    end
    @(negedge clk);
    rstn = 1'b1;
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_busy: got %b expected 0", busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_cfg_err();
    cfg_frame_len = 8'd0;
    cfg_num_frames = 3'd1;
    cfg_gap = '0;
    start = 1'b1;
    step();
    vectors++;
    if ({cfg_err, busy, stim_clr} !== 3'b100) begin
      miscompares++;
      $display("FAIL cfg_err_pulse: cfg_err/busy/clr %b expected 100", {cfg_err, busy, stim_clr});
    end
    step();
    vectors++;
    if ({cfg_err, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL cfg_err_one_cycle: cfg_err/busy %b expected 00", {cfg_err, busy});
    end
    $display("test_cfg_err done");
  endtask

  task automatic test_start_abort();
    cfg_frame_len = 8'd4;
    start = 1'b1;
    abort = 1'b1;
    step();
    vectors++;
    if ({busy, stim_clr, cfg_err, aborted, done, stim_en} !== 6'b0) begin
      miscompares++;
      $display("FAIL start_abort_idle: busy/clr/err/abt/done/en %b expected 000000",
               {busy, stim_clr, cfg_err, aborted, done, stim_en});
    end
    $display("test_start_abort done");
  endtask

  task automatic test_normal_seq();
    int clr_cnt;
    int done_cnt;
    int frames;
    int low_run;
    logic prev_en;
    int gaps[$];
    gen_len = 32;
    tready_val = 1'b1;
    cfg_frame_len = 8'd32;
    cfg_num_frames = 3'd3;
    cfg_gap = 16'd10;
    start = 1'b1;
    step();
    vectors++;
    if ({stim_clr, busy, stim_en} !== 3'b110 || stim_frame_len !== 8'd32 || frames_sent !== 3'd0) begin
      miscompares++;
      $display("FAIL seq_clr_entry: clr/busy/en %b len %0d frames %0d expected 110 32 0",
               {stim_clr, busy, stim_en}, stim_frame_len, frames_sent);
    end
    clr_cnt = 1; done_cnt = 0; frames = 0; low_run = 0; prev_en = 1'b0;
    for (int i = 0; i < 400 && busy; i++) begin
      step();
      if (stim_clr) clr_cnt++;
      if (done) done_cnt++;
      if (fe_seen) begin
        frames++;
        if (frames == 3) begin
          vectors++;
          if ({stim_en, done} !== 2'b01 || frames_sent !== 3'd3) begin
            miscompares++;
            $display("FAIL seq_last_frame: en/done %b frames %0d expected 01 3", {stim_en, done}, frames_sent);
          end
        end
      end
      if (prev_en && !stim_en) low_run = 1;
      else if (!prev_en && !stim_en && low_run > 0) low_run++;
      else if (!prev_en && stim_en && low_run > 0) begin
        gaps.push_back(low_run);
        low_run = 0;
      end
      prev_en = stim_en;
    end
    vectors++;
    if (busy !== 1'b0 || frames !== 3 || frames_sent !== 3'd3) begin
      miscompares++;
      $display("FAIL seq_complete: busy %b frames seen %0d frames_sent %0d expected 0 3 3", busy, frames, frames_sent);
    end
    vectors++;
    if (clr_cnt !== 1 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL seq_pulses: clr %0d done %0d expected 1 1", clr_cnt, done_cnt);
    end
    vectors++;
    if (gaps.size() !== 2) begin
      miscompares++;
      $display("FAIL seq_gap_count: got %0d expected 2", gaps.size());
    end else if (gaps[0] !== 10 || gaps[1] !== 10) begin
      miscompares++;
      $display("FAIL seq_gap_len: got %0d,%0d expected 10,10", gaps[0], gaps[1]);
    end
    $display("test_normal_seq done");
  endtask

  task automatic test_continuous_abort();
    int frames;
    int done_cnt;
    gen_len = 4;
    tready_val = 1'b1;
    cfg_frame_len = 8'd4;
    cfg_num_frames = 3'd0;
    cfg_gap = 16'd0;
    start = 1'b1;
    step();
    // Start while busy with an illegal length: ignored, and config stays latched.
    cfg_frame_len = 8'd0;
    cfg_num_frames = 3'd1;
    start = 1'b1;
    step();
    vectors++;
    if ({cfg_err, busy, stim_en} !== 3'b011 || stim_frame_len !== 8'd4) begin
      miscompares++;
      $display("FAIL busy_start_ignored: err/busy/en %b len %0d expected 011 4", {cfg_err, busy, stim_en}, stim_frame_len);
    end
    frames = 0; done_cnt = 0;
    for (int i = 0; i < 200 && frames < 5; i++) begin
      step();
      if (fe_seen) frames++;
      if (done) done_cnt++;
    end
    vectors++;
    if (frames_sent !== 3'd5 || stim_en !== 1'b1 || done_cnt !== 0) begin
      miscompares++;
      $display("FAIL cont_five_frames: frames %0d en %b done pulses %0d expected 5 1 0", frames_sent, stim_en, done_cnt);
    end
    abort = 1'b1;
    step();
    vectors++;
    if ({stim_en, aborted, busy, done} !== 4'b0100 || frames_sent !== 3'd5) begin
      miscompares++;
      $display("FAIL cont_abort: en/abt/busy/done %b frames %0d expected 0100 5", {stim_en, aborted, busy, done}, frames_sent);
    end
    step();
    vectors++;
    if (aborted !== 1'b0 || frames_sent !== 3'd5) begin
      miscompares++;
      $display("FAIL cont_abort_pulse: aborted %b frames %0d expected 0 5", aborted, frames_sent);
    end
    $display("test_continuous_abort done");
  endtask

  task automatic test_wrap();
    int frames;
    gen_len = 1;
    cfg_frame_len = 8'd1;
    cfg_num_frames = 3'd0;
    cfg_gap = 16'd2;
    start = 1'b1;
    step();
    frames = 0;
    for (int i = 0; i < 200 && frames < 9; i++) begin
      step();
      if (fe_seen) frames++;
    end
    vectors++;
    if (frames_sent !== 3'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_count: frames %0d busy %b expected 1 1", frames_sent, busy);
    end
    abort = 1'b1;
    step();
    // Handshake with tlast while IDLE must not be counted.
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast = 1'b1;
    step();
    vectors++;
    if (frames_sent !== 3'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_tlast_ignored: frames %0d busy %b expected 1 0", frames_sent, busy);
    end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid_run();
    gen_len = 8;
    cfg_frame_len = 8'd8;
    cfg_num_frames = 3'd0;
    cfg_gap = 16'd0;
    start = 1'b1;
    step();
    repeat (5) step();
    vectors++;
    if (stim_en !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_running: stim_en %b expected 1", stim_en);
    end
    rstn = 1'b0;
    #1;
    vectors++;
    if ({stim_en, stim_clr, busy, done, aborted, cfg_err, timeout} !== 7'b0 ||
        stim_frame_len !== 8'd0 || frames_sent !== 3'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: flags %b len %0d frames %0d expected 0 0 0",
               {stim_en, stim_clr, busy, done, aborted, cfg_err, timeout}, stim_frame_len, frames_sent);
    end
    mon_tvalid = 1'b0;
    mon_tlast = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step();
    vectors++;
    if ({done, aborted, busy, stim_en} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrun_after_release: done/abt/busy/en %b expected 0000", {done, aborted, busy, stim_en});
    end
    $display("test_reset_mid_run done");
  endtask

`ifdef AXIS_STIM_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int run_cycles;
    gen_len = 8;
    tready_val = 1'b0;
    cfg_frame_len = 8'd8;
    cfg_num_frames = 3'd0;
    start = 1'b1;
    step();
    run_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (aborted) break;
      if (stim_en) run_cycles++;
    end
    vectors++;
    if (run_cycles !== 100 || {timeout, aborted, busy, stim_en} !== 4'b1100) begin
      miscompares++;
      $display("FAIL timeout_fire: run cycles %0d to/abt/busy/en %b expected 100 1100",
               run_cycles, {timeout, aborted, busy, stim_en});
    end
    step();
    vectors++;
    if ({timeout, aborted} !== 2'b10) begin
      miscompares++;
      $display("FAIL timeout_sticky: to/abt %b expected 10", {timeout, aborted});
    end
    tready_val = 1'b1;
    start = 1'b1;
    step();
    vectors++;
    if ({timeout, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL timeout_clear_on_start: to/busy %b expected 01", {timeout, busy});
    end
    abort = 1'b1;
    step();
    $display("test_timeout done");
  endtask
`else
  task automatic test_timeout();
    gen_len = 8;
    tready_val = 1'b0;
    cfg_frame_len = 8'd8;
    cfg_num_frames = 3'd0;
    start = 1'b1;
    step();
    repeat (150) step();
    vectors++;
    if ({timeout, busy, stim_en} !== 3'b011) begin
      miscompares++;
      $display("FAIL no_watchdog: to/busy/en %b expected 011", {timeout, busy, stim_en});
    end
    tready_val = 1'b1;
    abort = 1'b1;
    step();
    $display("test_timeout done");
  endtask
`endif

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_frame_len = '0;
    cfg_num_frames = '0;
    cfg_gap = '0;
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast = 1'b0;
    test_reset();
    test_cfg_err();
    test_start_abort();
    test_normal_seq();
    test_continuous_abort();
    test_wrap();
    test_reset_mid_run();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
